// File: rtl/payload_arbiter_pkg.sv
// Shared types and constants for the payload arbiter.
// Holds the FSM state encoding and logic-level names.
package payload_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  localparam logic ON    = 1'b1;
  localparam logic OFF   = 1'b0;
  localparam int   CNT_W = 8;

endpackage

// File: rtl/payload_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Returns the first set request at or after ptr, wrapping.
module rr_pick
  import payload_arbiter_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int SRC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic             valid,
  output logic [SRC_W-1:0] idx
);

  // Scan from the farthest offset down so the nearest one wins.
  always_comb begin
    valid = OFF;
    idx   = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % N_SRC;
      if (req[j]) begin
        valid = ON;
        idx   = SRC_W'(j);
      end
    end
  end

endmodule

// File: rtl/payload_arbiter.sv
// Shares one coder between N_SRC payload sources.
// Round-robin grant, start strobe, busy/done wait, ack timeout.
module payload_arbiter
  import payload_arbiter_pkg::*;
#(
  parameter int N_SRC       = 4,
  parameter int DW          = 8,
  parameter int ACK_TIMEOUT = 15,
  localparam int SRC_W      = $clog2(N_SRC)
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clk_en,
  input  logic [N_SRC-1:0]    src_rdy,
  input  logic [N_SRC*DW-1:0] src_data,
  output logic [N_SRC-1:0]    src_busy,
  output logic                cd_start,
  output logic [DW-1:0]       cd_data,
  output logic [SRC_W-1:0]    cd_src,
  input  logic                cd_busy,
  output logic                err_timeout
);

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_SRC-1:0]   req_mask_q, req_mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               cd_start_q, cd_start_d;
  logic [DW-1:0]      cd_data_q, cd_data_d;
  logic [SRC_W-1:0]   cd_src_q, cd_src_d;
  logic [N_SRC-1:0]   src_busy_q, src_busy_d;
  logic               err_q, err_d;
  logic               pick_valid;
  logic [SRC_W-1:0]   pick_idx;

  rr_pick #(
    .N_SRC (N_SRC),
    .SRC_W (SRC_W)
  ) u_pick (
    .req   (src_rdy & ~req_mask_q),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    req_mask_d = req_mask_q;
    cnt_d      = cnt_q;
    cd_start_d = cd_start_q;
    cd_data_d  = cd_data_q;
    cd_src_d   = cd_src_q;
    src_busy_d = src_busy_q;
    err_d      = err_q;
    if (clk_en) begin
      cd_start_d = OFF;
      err_d      = OFF;
      // A dropped ready re-arms that source for a later grant.
      req_mask_d = req_mask_q & src_rdy;
      case (state_q)
        IDLE: begin
          src_busy_d = '0;
          if (pick_valid && !cd_busy) begin
            cd_start_d           = ON;
            cd_data_d            = src_data[pick_idx*DW +: DW];
            cd_src_d             = pick_idx;
            src_busy_d[pick_idx] = ON;
            req_mask_d[pick_idx] = ON;
            rr_ptr_d = (pick_idx == SRC_W'(N_SRC - 1)) ?
                       '0 : pick_idx + SRC_W'(1);
            state_d  = ISSUE;
          end
        end
        ISSUE: begin
          cnt_d   = '0;
          state_d = WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (cd_busy) begin
            state_d = WAIT_DONE;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(ACK_TIMEOUT)) begin
              err_d      = ON;
              src_busy_d = '0;
              state_d    = IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (!cd_busy) begin
            src_busy_d = '0;
            state_d    = IDLE;
          end
        end
        default: begin
          src_busy_d = '0;
          state_d    = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      req_mask_q <= '0;
      cnt_q      <= '0;
      cd_start_q <= OFF;
      cd_data_q  <= '0;
      cd_src_q   <= '0;
      src_busy_q <= '0;
      err_q      <= OFF;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      req_mask_q <= req_mask_d;
      cnt_q      <= cnt_d;
      cd_start_q <= cd_start_d;
      cd_data_q  <= cd_data_d;
      cd_src_q   <= cd_src_d;
      src_busy_q <= src_busy_d;
      err_q      <= err_d;
    end
  end

  assign src_busy    = src_busy_q;
  assign cd_start    = cd_start_q;
  assign cd_data     = cd_data_q;
  assign cd_src      = cd_src_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_payload_arbiter.sv
// Directed bench for payload_arbiter, N_SRC=4, DW=8.
// Inputs change and outputs are sampled on the falling edge.
module tb_payload_arbiter;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        clk_en;
  logic [3:0]  src_rdy;
  logic [31:0] src_data;
  logic [3:0]  src_busy;
  logic        cd_start;
  logic [7:0]  cd_data;
  logic [1:0]  cd_src;
  logic        cd_busy;
  logic        err_timeout;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  payload_arbiter #(
    .N_SRC       (4),
    .DW          (8),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .clk_en      (clk_en),
    .src_rdy     (src_rdy),
    .src_data    (src_data),
    .src_busy    (src_busy),
    .cd_start    (cd_start),
    .cd_data     (cd_data),
    .cd_src      (cd_src),
    .cd_busy     (cd_busy),
    .err_timeout (err_timeout)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic grant_chk(input int s, input logic [7:0] d);
    logic [3:0] oh;
    oh = 4'b0001 << s;
    chk("g_start", 32'(cd_start), 32'd1);
    chk("g_src", 32'(cd_src), 32'(s));
    chk("g_data", 32'(cd_data), 32'(d));
    chk("g_busy", 32'(src_busy), 32'(oh));
  endtask

  // Grant from IDLE, ack immediately, finish back in IDLE.
  task automatic xfer(input int s, input logic [7:0] d);
    tick();
    grant_chk(s, d);
    tick();
    chk("x_start_off", 32'(cd_start), 32'd0);
    cd_busy = 1'b1;
    tick();
    cd_busy = 1'b0;
    tick();
    chk("x_busy_clr", 32'(src_busy), 32'd0);
  endtask

  initial begin
    n_rst    = 1'b0;
    clk_en   = 1'b1;
    src_rdy  = 4'b0000;
    src_data = '0;
    cd_busy  = 1'b0;
    tick();
    tick();
    chk("rst_start", 32'(cd_start), 32'd0);
    chk("rst_busy", 32'(src_busy), 32'd0);
    chk("rst_data", 32'(cd_data), 32'd0);
    chk("rst_src", 32'(cd_src), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    n_rst = 1'b1;

    // 1: single source, coder busy two ticks after start for five
    src_data[7:0] = 8'hA5;
    src_rdy       = 4'b0001;
    tick();
    grant_chk(0, 8'hA5);
    src_rdy = 4'b0000;
    tick();
    chk("t1_start_1t", 32'(cd_start), 32'd0);
    chk("t1_busy_a", 32'(src_busy), 32'd1);
    cd_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_busy_hold", 32'(src_busy), 32'd1);
    end
    cd_busy = 1'b0;
    tick();
    chk("t1_busy_clr", 32'(src_busy), 32'd0);
    chk("t1_data_hold", 32'(cd_data), 32'hA5);

    // 2: all ready, round robin 0..3, repeat only after a drop
    n_rst = 1'b0;
    tick();
    n_rst    = 1'b1;
    src_data = {8'h44, 8'h33, 8'h22, 8'h11};
    src_rdy  = 4'b1111;
    xfer(0, 8'h11);
    xfer(1, 8'h22);
    xfer(2, 8'h33);
    xfer(3, 8'h44);
    tick();
    chk("t2_no_regrant", 32'(cd_start), 32'd0);
    src_rdy = 4'b0000;
    tick();
    src_rdy = 4'b1111;
    xfer(0, 8'h11);

    // 3: coder never acks
    src_rdy = 4'b0010;
    tick();
    grant_chk(1, 8'h22);
    src_rdy = 4'b0110;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("t3_no_err", 32'(err_timeout), 32'd0);
      chk("t3_busy", 32'(src_busy), 32'b0010);
    end
    tick();
    chk("t3_err", 32'(err_timeout), 32'd1);
    chk("t3_busy_clr", 32'(src_busy), 32'd0);
    tick();
    chk("t3_err_1t", 32'(err_timeout), 32'd0);
    grant_chk(2, 8'h33);

    // 4: clk_en gaps freeze state and outputs
    src_rdy = 4'b0000;
    clk_en  = 1'b0;
    tick();
    chk("t4_start_frz", 32'(cd_start), 32'd1);
    chk("t4_busy_frz", 32'(src_busy), 32'b0100);
    clk_en = 1'b1;
    tick();
    chk("t4_start_off", 32'(cd_start), 32'd0);
    cd_busy = 1'b1;
    tick();
    chk("t4_wd", 32'(src_busy), 32'b0100);
    cd_busy = 1'b0;
    clk_en  = 1'b0;
    tick();
    chk("t4_frz_a", 32'(src_busy), 32'b0100);
    clk_en  = 1'b1;
    cd_busy = 1'b1;
    tick();
    chk("t4_wd_b", 32'(src_busy), 32'b0100);
    clk_en  = 1'b0;
    cd_busy = 1'b0;
    tick();
    chk("t4_frz_b", 32'(src_busy), 32'b0100);
    clk_en = 1'b1;
    tick();
    chk("t4_done", 32'(src_busy), 32'd0);
    chk("t4_data_hold", 32'(cd_data), 32'h33);

    // 5: reset while in WAIT_DONE, with clk_en low
    src_rdy = 4'b1000;
    tick();
    grant_chk(3, 8'h44);
    tick();
    cd_busy = 1'b1;
    tick();
    chk("t5_wd", 32'(src_busy), 32'b1000);
    src_rdy = 4'b0000;
    n_rst   = 1'b0;
    clk_en  = 1'b0;
    tick();
    chk("t5_start", 32'(cd_start), 32'd0);
    chk("t5_busy", 32'(src_busy), 32'd0);
    chk("t5_data", 32'(cd_data), 32'd0);
    chk("t5_src", 32'(cd_src), 32'd0);
    chk("t5_err", 32'(err_timeout), 32'd0);
    n_rst  = 1'b1;
    clk_en = 1'b1;

    // 6: coder busy from elsewhere blocks grant; ptr back at 0
    src_rdy = 4'b1010;
    tick();
    chk("t6_block_a", 32'(cd_start), 32'd0);
    chk("t6_nobusy", 32'(src_busy), 32'd0);
    src_data[15:8] = 8'h5A;
    tick();
    chk("t6_block_b", 32'(cd_start), 32'd0);
    cd_busy = 1'b0;
    tick();
    grant_chk(1, 8'h5A);
    src_data[15:8] = 8'h77;
    tick();
    chk("t6_data_hold", 32'(cd_data), 32'h5A);
    chk("t6_start_off", 32'(cd_start), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
